// File: rtl/alu_exec_if.sv
// Handshake and operand/result bundle between the EX-stage issue logic and alu_exec.
// The master side issues operations and consumes results; the slave side is the execute unit.
interface alu_exec_if #(
    parameter int DATA_W = 64
) ();
    logic              i_valid;
    logic              o_ready;
    logic [2:0]        i_alu_control;
    logic [DATA_W-1:0] i_src1;
    logic [DATA_W-1:0] i_src2;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_result;
    logic              o_zero;
    logic              o_busy;

    modport master (
        output i_valid, i_alu_control, i_src1, i_src2, i_ready,
        input  o_ready, o_valid, o_result, o_zero, o_busy
    );

    modport slave (
        input  i_valid, i_alu_control, i_src1, i_src2, i_ready,
        output o_ready, o_valid, o_result, o_zero, o_busy
    );
endinterface

// File: rtl/alu_exec.sv
// Multi-cycle EX-stage execute unit: single-cycle logic/arithmetic ops and an
// iterative one-bit-per-cycle shifter, with valid/ready on both sides.
module alu_exec #(
    parameter int DATA_W = 64
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    alu_exec_if.slave bus
);
    localparam int SHW = $clog2(DATA_W);
    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              valid_r;
    logic              busy_r;
    logic              ready_s;
    logic [DATA_W-1:0] work_r;
    logic [SHW-1:0]    cnt_r;
    logic              left_r;
    logic [DATA_W-1:0] result_r;
    logic              zero_r;

    logic [SHW-1:0]    shamt_s;
    logic              is_shift_s;
    logic              accept_s;
    logic              start_shift_s;
    logic [DATA_W-1:0] calc_s;
    logic [DATA_W-1:0] shift_next_s;

    // Shifts reaching this function always have shamt == 0, so they pass A through;
    // the unused code 3'b111 falls into the ADD path.
    function automatic logic [DATA_W-1:0] alu_calc(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        case (op)
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a;
            OP_SRL:  r = a;
            default: r = a + b;
        endcase
        return r;
    endfunction

    assign shamt_s       = bus.i_src2[SHW-1:0];
    assign is_shift_s    = (bus.i_alu_control == OP_SLL) || (bus.i_alu_control == OP_SRL);
    assign accept_s      = bus.i_valid && ready_s;
    assign start_shift_s = is_shift_s && (shamt_s != '0);
    assign calc_s        = alu_calc(bus.i_alu_control, bus.i_src1, bus.i_src2);
    assign shift_next_s  = left_r ? {work_r[DATA_W-2:0], 1'b0} : {1'b0, work_r[DATA_W-1:1]};

    // State register; o_valid/o_busy are registered from the next state
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            valid_r <= (state_next_s == DONE);
            busy_r  <= (state_next_s == SHIFT);
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = start_shift_s ? SHIFT : DONE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CNT_ONE) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                if (accept_s) begin
                    state_next_s = start_shift_s ? SHIFT : DONE;
                end else if (bus.i_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Upstream ready; the i_ready -> o_ready path in DONE allows back-to-back issue
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            IDLE:    ready_s = 1'b1;
            DONE:    ready_s = bus.i_ready;
            SHIFT:   ready_s = 1'b0;
            default: ready_s = 1'b0;
        endcase
    end

    // Operand capture, iterative shifter and result register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            work_r   <= '0;
            cnt_r    <= '0;
            left_r   <= 1'b0;
            result_r <= '0;
            zero_r   <= 1'b0;
        end else if (accept_s) begin
            if (start_shift_s) begin
                work_r <= bus.i_src1;
                cnt_r  <= shamt_s;
                left_r <= (bus.i_alu_control == OP_SLL);
            end else begin
                result_r <= calc_s;
                zero_r   <= (calc_s == '0);
            end
        end else if (state_r == SHIFT) begin
            work_r <= shift_next_s;
            cnt_r  <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
                result_r <= shift_next_s;
                zero_r   <= (shift_next_s == '0);
            end else begin
                result_r <= result_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.o_ready  = ready_s;
    assign bus.o_valid  = valid_r;
    assign bus.o_busy   = busy_r;
    assign bus.o_result = result_r;
    assign bus.o_zero   = zero_r;
endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, handshake corner sequences,
// and random operations scored against an arithmetic reference model.
module tb_alu_exec;
    localparam int DATA_W = 64;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    alu_exec_if #(.DATA_W(DATA_W)) bus ();

    alu_exec #(.DATA_W(DATA_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        zero;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: result straight from the operation definitions
    function automatic logic [63:0] model_result(input logic [2:0] op, input logic [63:0] a,
                                                 input logic [63:0] b);
        int sh;
        sh = int'(b % 64);
        case (op)
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b101:  return a << sh;
            3'b110:  return a >> sh;
            default: return a + b;
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] op, input logic [63:0] b);
        int sh;
        sh = int'(b % 64);
        if ((op == 3'b101 || op == 3'b110) && sh != 0) return sh + 1;
        return 1;
    endfunction

    // Issue one op from IDLE with i_ready high, measure latency and check the result.
    task automatic run_op(input string name, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_res,
                          input logic exp_zero, input int exp_lat);
        int lat;
        int stall;
        bus.i_ready       = 1'b1;
        bus.i_valid       = 1'b1;
        bus.i_alu_control = op;
        bus.i_src1        = a;
        bus.i_src2        = b;
        check({name, " ready_at_issue"}, 64'(bus.o_ready), 64'd1);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_src1  = ~a;
        bus.i_src2  = ~b;
        lat   = 1;
        stall = 0;
        while (!bus.o_valid && lat < 100) begin
            if (bus.o_busy && !bus.o_ready) stall++;
            @(posedge clk); #1;
            lat++;
        end
        check({name, " valid"}, 64'(bus.o_valid), 64'd1);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " busy_cycles"}, 64'(stall), 64'(exp_lat - 1));
        check({name, " result"}, bus.o_result, exp_res);
        check({name, " zero"}, 64'(bus.o_zero), 64'(exp_zero));
        @(posedge clk); #1;
        check({name, " back_to_idle"}, 64'(bus.o_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic [2:0]  rop;
        logic [63:0] er;

        tests = 0;
        fails = 0;

        vecs[0] = '{3'b000, 64'd5, 64'd7, 64'd12, 1'b0, 1};
        vecs[1] = '{3'b101, 64'd1, 64'h44, 64'd16, 1'b0, 5};
        vecs[2] = '{3'b110, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0, 64};
        vecs[3] = '{3'b110, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1};
        vecs[4] = '{3'b001, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1};
        vecs[5] = '{3'b011, 64'hF000, 64'h000F, 64'hF00F, 1'b0, 1};
        vecs[6] = '{3'b111, 64'd5, 64'd7, 64'd12, 1'b0, 1};
        vecs[7] = '{3'b101, 64'h3, 64'h101, 64'h6, 1'b0, 2};
        vecs[8] = '{3'b101, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 1'b1, 2};
        vecs[9] = '{3'b010, 64'hAAAA, 64'h5555, 64'd0, 1'b1, 1};

        rst_n             = 1'b0;
        bus.i_valid       = 1'b0;
        bus.i_ready       = 1'b1;
        bus.i_alu_control = 3'b000;
        bus.i_src1        = 64'd0;
        bus.i_src2        = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset o_valid", 64'(bus.o_valid), 64'd0);
        check("reset o_result", bus.o_result, 64'd0);
        check("reset o_zero", 64'(bus.o_zero), 64'd0);
        check("reset o_busy", 64'(bus.o_busy), 64'd0);
        check("reset o_ready", 64'(bus.o_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].zero, vecs[i].lat);
        end

        // Back-to-back: SUB then XOR accepted in DONE
        bus.i_valid = 1'b1; bus.i_alu_control = 3'b001; bus.i_src1 = 64'd9; bus.i_src2 = 64'd9;
        @(posedge clk); #1;
        check("b2b sub valid", 64'(bus.o_valid), 64'd1);
        check("b2b sub result", bus.o_result, 64'd0);
        check("b2b sub zero", 64'(bus.o_zero), 64'd1);
        check("b2b ready in done", 64'(bus.o_ready), 64'd1);
        bus.i_alu_control = 3'b100; bus.i_src1 = 64'hFF; bus.i_src2 = 64'h0F;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        check("b2b xor valid", 64'(bus.o_valid), 64'd1);
        check("b2b xor result", bus.o_result, 64'hF0);
        check("b2b xor zero", 64'(bus.o_zero), 64'd0);
        check("b2b ready", 64'(bus.o_ready), 64'd1);
        @(posedge clk); #1;
        check("b2b idle", 64'(bus.o_valid), 64'd0);

        // Backpressure: result held while i_ready low, new op refused
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1; bus.i_alu_control = 3'b010; bus.i_src1 = 64'hF0F0; bus.i_src2 = 64'hFF00;
        @(posedge clk); #1;
        bus.i_alu_control = 3'b000; bus.i_src1 = 64'd1; bus.i_src2 = 64'd1;
        for (int c = 0; c < 3; c++) begin
            check("bp valid", 64'(bus.o_valid), 64'd1);
            check("bp result", bus.o_result, 64'hF000);
            check("bp zero", 64'(bus.o_zero), 64'd0);
            check("bp ready", 64'(bus.o_ready), 64'd0);
            @(posedge clk); #1;
        end
        check("bp still held", bus.o_result, 64'hF000);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release idle", 64'(bus.o_valid), 64'd0);
        check("bp release ready", 64'(bus.o_ready), 64'd1);

        // Reset in the middle of a long shift
        bus.i_valid = 1'b1; bus.i_alu_control = 3'b101; bus.i_src1 = 64'd1; bus.i_src2 = 64'd10;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid-shift busy", 64'(bus.o_busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst mid o_valid", 64'(bus.o_valid), 64'd0);
        check("rst mid o_busy", 64'(bus.o_busy), 64'd0);
        check("rst mid o_result", bus.o_result, 64'd0);
        check("rst mid o_zero", 64'(bus.o_zero), 64'd0);
        check("rst mid o_ready", 64'(bus.o_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post-reset add", 3'b000, 64'd1, 64'd2, 64'd3, 1'b0, 1);

        // Random ops against the reference model
        for (int n = 0; n < 150; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if (n % 5 == 0) rb = ra;
            if (n % 7 == 0) ra = 64'd0;
            er = model_result(rop, ra, rb);
            run_op($sformatf("rand%0d op%0d", n, rop), rop, ra, rb, er, (er == 64'd0),
                   model_latency(rop, rb));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_exec.md
# alu_exec

Multi-cycle execute unit that consumes the 3-bit ALU control code produced by the ALU control decoder and performs the operation on two DATA_W operands. It sits in the EX stage. It uses a valid/ready handshake on both sides, so the pipeline can stall while long operations complete. ADD/SUB/AND/OR/XOR finish in one cycle. SLL/SRL run on an iterative one-bit-per-cycle shifter, so their latency depends on the shift amount.

## Interface
- DATA_W, 64, operand/result width; power of two, ≥ 8
- ADD, 3'b000, add code
- SUB, 3'b001, subtract code
- AND, 3'b010, bitwise-and code
- OR, 3'b011, bitwise-or code
- XOR, 3'b100, bitwise-xor code
- SLL, 3'b101, logical-left-shift code
- SRL, 3'b110, logical-right-shift code

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset; synchronous, active-low
- i_valid  in  1  upstream has an operation
- o_ready  out  1  block can accept an operation this cycle
- i_alu_control  in  3  operation code
- i_src1  in  DATA_W  operand A
- i_src2  in  DATA_W  operand B; low log2(DATA_W) bits are the shift amount for shifts
- o_valid  out  1  o_result/o_zero are valid
- i_ready  in  1  downstream accepts the result
- o_result  out  DATA_W  result
- o_zero  out  1  high when o_result == 0
- o_busy  out  1  high while in SHIFT

## Operation
- States: IDLE, SHIFT, DONE.
- Accept happens on the edge where i_valid && o_ready. The opcode and both operands are captured into internal registers. Later input changes are ignored.
- o_ready is high in IDLE. It is also high in DONE when i_ready is high, which allows back-to-back accept. It is low in SHIFT. The combinational path i_ready → o_ready is intended.
- Arithmetic is modulo 2^DATA_W with no carry or overflow outputs.
- SUB is A − B in two's complement.
- Shifts are logical: zero fill.
- Shift amount is shamt = src2[log2(DATA_W)−1:0]; upper bits are ignored.
- Code 3'b111 (never generated by the decoder) executes as ADD.
- Non-shift op, or shift with shamt == 0: go IDLE → DONE with the result registered at the accept edge.
- Shift with shamt > 0:
  - At accept: load the working register with A and the down-counter with shamt, then go to SHIFT.
  - Each SHIFT cycle: shift one bit and decrement the counter.
  - When the counter reaches 0: go to DONE with the final value.
- DONE, handshake cases:
  - i_ready low: hold all outputs stable.
  - i_ready high and no new accept: go to IDLE.
  - i_ready high and new accept: behave as an accept from IDLE.
- o_zero is registered together with o_result.

## Timing
- Reset, applied at any edge with i_rst_n low, from any state including mid-SHIFT:
  - state → IDLE; any in-flight op is discarded
  - o_valid = 0, o_result = 0, o_zero = 0, o_busy = 0
  - counter = 0
  - o_ready = 1 in the first cycle after reset
- Latency, from accept edge to the first cycle o_valid is high:
  - 1 cycle for non-shift ops and shamt = 0
  - shamt + 1 cycles for shifts
  - maximum is DATA_W cycles (shamt = DATA_W−1)
- o_valid is high only in DONE. o_busy is high only in SHIFT.
- Throughput:
  - one non-shift op per cycle when i_ready is held high
  - a shift occupies shamt + 1 cycles before the next op can be accepted
- o_result and o_zero are undefined-as-zero (hold last value) outside DONE. The bench checks them only when o_valid is high.

## Test plan
- **ADD:** ADD, A=5, B=7, i_ready=1 → o_valid high 1 cycle after accept, o_result=12, o_zero=0, back to IDLE next cycle.
- **SUB and back-to-back:** SUB with A=B=9, then XOR with A=0xFF, B=0x0F on the next cycle, i_ready=1.
  - SUB → o_result=0, o_zero=1.
  - XOR accepted in DONE → o_result=0xF0 one cycle later.
  - o_ready never drops.
- **SLL:** SLL, A=1, B=0x44 (shamt=4) → o_busy and o_ready low for 4 cycles, o_valid 5 cycles after accept, o_result=16.
- **SRL maximum shift:** SRL, A=0x8000_0000_0000_0000, B=63 → o_valid 64 cycles after accept, o_result=1. Also SRL with B=0 → 1-cycle latency, o_result=A.
- **Backpressure:** AND, A=0xF0F0, B=0xFF00, i_ready low 3 cycles → o_valid, o_result=0xF000 and o_zero held stable, o_ready low, new i_valid not accepted; i_ready high → IDLE next cycle.
- **Reset mid-shift:** i_rst_n low during SLL shamt=10, cycle 3 → all outputs 0 next edge, o_ready=1. Then ADD with A=1, B=2 → o_result=3.
